aibcr3aux_osc_rdy_mon: RTL and testbench
========================================

AIBCR3AUX_OSC_RDY_MON -- requirements
Module: aibcr3aux_osc_rdy_mon

Interface
REQ-001 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 The module SHALL have port rstb, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 The module SHALL have port dly_q, input, 1 bit: delayed-ready flag from the oscillator delay chain; asynchronous to clk.
REQ-004 The module SHALL have port osc_tgl, input, 1 bit: divided oscillator toggle used as the liveness indication; asynchronous to clk.
REQ-005 The module SHALL have port cfg_settle, input, 8 bits: settle cycles after ready is seen; quasi-static.
REQ-006 The module SHALL have port cfg_timeout, input, 8 bits: watchdog limit in cycles; 0 disables the watchdog; quasi-static.
REQ-007 The module SHALL have port clr_lost, input, 1 bit: clears a sticky loss; synchronous.
REQ-008 The module SHALL have port osc_rdy, output, 1 bit: oscillator qualified and alive.
REQ-009 The module SHALL have port osc_lost, output, 1 bit: sticky loss-of-toggle flag.
REQ-010 The module SHALL have port state, output, 2 bits: FSM state encoding for debug.
REQ-011 Parameter SYNC_STAGES, default 2, SHALL set the synchronizer depth for dly_q and osc_tgl (minimum 2).

Function
REQ-012 dly_q SHALL pass through a SYNC_STAGES flop synchronizer; the result is dly_s.
REQ-013 osc_tgl SHALL pass through a SYNC_STAGES synchronizer plus one history flop; tgl_edge = last sync stage XOR history flop.
REQ-014 The FSM SHALL have four states: IDLE=0, SETTLE=1, READY=2, LOST=3.
REQ-015 IDLE: on dly_s=1, go to READY if cfg_settle==0, else go to SETTLE with settle_cnt=0.
REQ-016 SETTLE: settle_cnt increments each cycle; when settle_cnt==cfg_settle-1, go to READY.
REQ-017 With SYNC_STAGES=2, if dly_q is first sampled high at edge t, osc_rdy SHALL be high after edge t+2+cfg_settle.
REQ-018 READY: osc_rdy=1; the 8-bit wd_cnt clears on tgl_edge and otherwise increments.
REQ-019 READY: when wd_cnt==cfg_timeout-1 with no tgl_edge (and cfg_timeout!=0), go to LOST; this gives cfg_timeout consecutive edgeless cycles.
REQ-020 If tgl_edge and the timeout condition occur in the same cycle, tgl_edge SHALL win and the state stays READY.
REQ-021 In SETTLE or READY, dly_s=0 SHALL force IDLE next cycle, clearing settle_cnt and wd_cnt; this takes priority over every other transition.
REQ-022 LOST: osc_rdy=0 and osc_lost=1; on clr_lost=1, go to IDLE and clear osc_lost; dly_s is ignored while in LOST.
REQ-023 clr_lost SHALL be ignored in states other than LOST.
REQ-024 Counters SHALL never wrap: settle_cnt is bounded by cfg_settle and wd_cnt by cfg_timeout; with cfg_timeout=0, wd_cnt holds at 0.
REQ-025 osc_rdy and osc_lost SHALL be registered outputs, glitch-free; osc_rdy=1 only in READY.

Reset
REQ-026 rstb=0 SHALL asynchronously clear all synchronizer flops, counters, state (IDLE), osc_rdy=0 and osc_lost=0.
REQ-027 Reset mid-operation SHALL abort any state immediately; after release, qualification restarts from IDLE.
REQ-028 rstb deassertion SHALL be externally synchronized to clk.

Structure
REQ-029 The state encoding and the SYNC_STAGES default SHALL live in a shared aibcr3aux package.
REQ-030 The synchronizer SHALL be one sub-module, aibcr3aux_osc_sync, instantiated twice.

Verification
REQ-031 Settle test: cfg_settle=5, cfg_timeout=0, dly_q rises at sampling edge t -> osc_rdy rises after edge t+7; state sequence 0,1,2.
REQ-032 Zero settle: cfg_settle=0, dly_q rises at t -> osc_rdy high after edge t+2; SETTLE never visited.
REQ-033 Watchdog: cfg_timeout=4, osc_tgl held constant in READY -> LOST after 4 edgeless cycles, osc_rdy=0, osc_lost=1; osc_tgl toggling every 3 cycles keeps READY indefinitely.
REQ-034 Tie case: tgl_edge lands in the cycle where wd_cnt==3 with cfg_timeout=4 -> remains READY, wd_cnt=0.
REQ-035 Drop/clear: dly_q falls during SETTLE -> IDLE, osc_rdy stays 0; in LOST, assert clr_lost with dly_q=1 -> IDLE then re-qualifies through SETTLE.
REQ-036 Async reset asserted mid-READY (not clock-aligned) -> osc_rdy=0, state=0 before the next clk edge.

Source files
------------

// File: rtl/aibcr3aux_osc_rdy_mon_pkg.sv
// Shared types and defaults for the AIB aux oscillator ready monitor.
// Holds the FSM state encoding, the synchronizer depth default and a counter helper.
package aibcr3aux_osc_rdy_mon_pkg;

    localparam int OSC_SYNC_STAGES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_READY  = 2'd2,
        ST_LOST   = 2'd3
    } osc_state_e;

    // Terminal-count test written as >= so a count can never run past its
    // limit, even if a quasi-static limit is lowered while counting.
    function automatic logic cnt_hit(input logic [7:0] cnt, input logic [7:0] limit);
        return (cnt >= (limit - 8'd1));
    endfunction

endpackage

// File: rtl/aibcr3aux_osc_sync.sv
// Multi-flop synchronizer for one asynchronous control bit.
// Depth below 2 is not a valid configuration.
module aibcr3aux_osc_sync
    import aibcr3aux_osc_rdy_mon_pkg::*;
#(
    parameter int STAGES = OSC_SYNC_STAGES_DEF
) (
    input  logic clk,
    input  logic rstb,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/aibcr3aux_osc_rdy_mon.sv
// Oscillator ready monitor: qualifies the delayed-ready flag, waits a settle
// period, then watches the divided oscillator toggle for loss of activity.
module aibcr3aux_osc_rdy_mon
    import aibcr3aux_osc_rdy_mon_pkg::*;
#(
    parameter int SYNC_STAGES = OSC_SYNC_STAGES_DEF
) (
    input  logic       clk,
    input  logic       rstb,
    input  logic       dly_q,
    input  logic       osc_tgl,
    input  logic [7:0] cfg_settle,
    input  logic [7:0] cfg_timeout,
    input  logic       clr_lost,
    output logic       osc_rdy,
    output logic       osc_lost,
    output logic [1:0] state
);

    osc_state_e st;
    logic       dly_s;
    logic       tgl_s;
    logic       tgl_h;
    logic       tgl_edge;
    logic [7:0] settle_cnt;
    logic [7:0] wd_cnt;

    aibcr3aux_osc_sync #(.STAGES(SYNC_STAGES)) u_sync_dly (
        .clk  (clk),
        .rstb (rstb),
        .d    (dly_q),
        .q    (dly_s)
    );

    aibcr3aux_osc_sync #(.STAGES(SYNC_STAGES)) u_sync_tgl (
        .clk  (clk),
        .rstb (rstb),
        .d    (osc_tgl),
        .q    (tgl_s)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            tgl_h <= 1'b0;
        end else begin
            tgl_h <= tgl_s;
        end
    end

    // Either polarity change of the divided clock counts as proof of life.
    assign tgl_edge = tgl_s ^ tgl_h;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            st         <= ST_IDLE;
            settle_cnt <= 8'd0;
            wd_cnt     <= 8'd0;
            osc_rdy    <= 1'b0;
            osc_lost   <= 1'b0;
        end else begin
            case (st)
                ST_IDLE: begin
                    settle_cnt <= 8'd0;
                    wd_cnt     <= 8'd0;
                    if (dly_s) begin
                        if (cfg_settle == 8'd0) begin
                            st      <= ST_READY;
                            osc_rdy <= 1'b1;
                        end else begin
                            st <= ST_SETTLE;
                        end
                    end
                end
                ST_SETTLE: begin
                    if (!dly_s) begin
                        st         <= ST_IDLE;
                        settle_cnt <= 8'd0;
                    end else if (cnt_hit(settle_cnt, cfg_settle)) begin
                        st         <= ST_READY;
                        osc_rdy    <= 1'b1;
                        settle_cnt <= 8'd0;
                        wd_cnt     <= 8'd0;
                    end else begin
                        settle_cnt <= settle_cnt + 8'd1;
                    end
                end
                ST_READY: begin
                    // Loss of the ready flag beats everything; a toggle beats the timeout.
                    if (!dly_s) begin
                        st      <= ST_IDLE;
                        osc_rdy <= 1'b0;
                        wd_cnt  <= 8'd0;
                    end else if (tgl_edge) begin
                        wd_cnt <= 8'd0;
                    end else if (cfg_timeout == 8'd0) begin
                        wd_cnt <= 8'd0;
                    end else if (cnt_hit(wd_cnt, cfg_timeout)) begin
                        st       <= ST_LOST;
                        osc_rdy  <= 1'b0;
                        osc_lost <= 1'b1;
                        wd_cnt   <= 8'd0;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
                end
                ST_LOST: begin
                    if (clr_lost) begin
                        st       <= ST_IDLE;
                        osc_lost <= 1'b0;
                    end
                end
                default: begin
                    st       <= ST_IDLE;
                    osc_rdy  <= 1'b0;
                    osc_lost <= 1'b0;
                end
            endcase
        end
    end

    assign state = st;

endmodule

// File: tb/tb_aibcr3aux_osc_rdy_mon.sv
// Self-checking bench for the oscillator ready monitor: expected per-cycle
// {state, osc_rdy, osc_lost} tuples are queued per scenario and compared at negedge.
module tb_aibcr3aux_osc_rdy_mon;

    logic       clk;
    logic       rstb;
    logic       dly_q;
    logic       osc_tgl;
    logic [7:0] cfg_settle;
    logic [7:0] cfg_timeout;
    logic       clr_lost;
    logic       osc_rdy;
    logic       osc_lost;
    logic [1:0] state;

    logic [3:0] exp_q[$];
    int         n_checks;
    int         n_pass;

    aibcr3aux_osc_rdy_mon dut (
        .clk         (clk),
        .rstb        (rstb),
        .dly_q       (dly_q),
        .osc_tgl     (osc_tgl),
        .cfg_settle  (cfg_settle),
        .cfg_timeout (cfg_timeout),
        .clr_lost    (clr_lost),
        .osc_rdy     (osc_rdy),
        .osc_lost    (osc_lost),
        .state       (state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns at 1ns after a rising edge, with every flop cleared.
    task automatic do_reset();
        rstb     = 1'b0;
        dly_q    = 1'b0;
        osc_tgl  = 1'b0;
        clr_lost = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rstb = 1'b1;
    endtask

    // Scoreboard feed: I=IDLE, S=SETTLE, R=READY (rdy=1), L=LOST (lost=1).
    task automatic push_seq(input string s);
        byte c;
        for (int i = 0; i < s.len(); i++) begin
            c = s.getc(i);
            case (c)
                "I":     exp_q.push_back(4'b00_0_0);
                "S":     exp_q.push_back(4'b01_0_0);
                "R":     exp_q.push_back(4'b10_1_0);
                default: exp_q.push_back(4'b11_0_1);
            endcase
        end
    endtask

    task automatic test_reset();
        rstb        = 1'b0;
        dly_q       = 1'b1;
        osc_tgl     = 1'b0;
        clr_lost    = 1'b0;
        cfg_settle  = 8'd0;
        cfg_timeout = 8'd0;
        #2;
        n_checks++;
        if (state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", state);
        else n_pass++;
        n_checks++;
        if (osc_rdy !== 1'b0) $display("FAIL reset_rdy: got %0b expected 0", osc_rdy);
        else n_pass++;
        n_checks++;
        if (osc_lost !== 1'b0) $display("FAIL reset_lost: got %0b expected 0", osc_lost);
        else n_pass++;
    endtask

    // cfg_settle=5: READY after edge t+7, then a drop from READY returns to IDLE.
    task automatic test_settle();
        logic [3:0] got, expv;
        int k;
        do_reset();
        cfg_settle  = 8'd5;
        cfg_timeout = 8'd0;
        dly_q       = 1'b1;
        push_seq("IISSSSSRRRRRRRRRII");
        k = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            k++;
            #1;
            if (k == 14) dly_q = 1'b0;
            @(negedge clk);
            got  = {state, osc_rdy, osc_lost};
            expv = exp_q.pop_front();
            n_checks++;
            if (got !== expv)
                $display("FAIL settle cyc %0d: got st/rdy/lost=%0d/%0b/%0b expected %0d/%0b/%0b",
                         k, got[3:2], got[1], got[0], expv[3:2], expv[1], expv[0]);
            else n_pass++;
        end
    endtask

    task automatic test_zero_settle();
        logic [3:0] got, expv;
        int k;
        do_reset();
        cfg_settle  = 8'd0;
        cfg_timeout = 8'd0;
        dly_q       = 1'b1;
        push_seq("IIRRR");
        k = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            got  = {state, osc_rdy, osc_lost};
            expv = exp_q.pop_front();
            n_checks++;
            if (got !== expv)
                $display("FAIL zero_settle cyc %0d: got st/rdy/lost=%0d/%0b/%0b expected %0d/%0b/%0b",
                         k, got[3:2], got[1], got[0], expv[3:2], expv[1], expv[0]);
            else n_pass++;
        end
    endtask

    // Timeout 4 with a dead toggle; LOST holds with dly_q high, clr_lost re-qualifies.
    task automatic test_watchdog();
        logic [3:0] got, expv;
        int k;
        do_reset();
        cfg_settle  = 8'd2;
        cfg_timeout = 8'd4;
        dly_q       = 1'b1;
        push_seq("IISSRRRRLLLLISSRRRRL");
        k = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            k++;
            #1;
            if (k == 12) clr_lost = 1'b1;
            if (k == 13) clr_lost = 1'b0;
            @(negedge clk);
            got  = {state, osc_rdy, osc_lost};
            expv = exp_q.pop_front();
            n_checks++;
            if (got !== expv)
                $display("FAIL watchdog cyc %0d: got st/rdy/lost=%0d/%0b/%0b expected %0d/%0b/%0b",
                         k, got[3:2], got[1], got[0], expv[3:2], expv[1], expv[0]);
            else n_pass++;
        end
    endtask

    // Toggle every 3 cycles keeps READY; clr_lost held high must have no effect.
    task automatic test_keepalive();
        logic [3:0] got, expv;
        int k;
        do_reset();
        cfg_settle  = 8'd0;
        cfg_timeout = 8'd4;
        dly_q       = 1'b1;
        clr_lost    = 1'b1;
        push_seq("IIRRRRRRRRRRRRRRRRRRRRRRRRRRRR");
        k = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            k++;
            #1;
            if (k % 3 == 0) osc_tgl = ~osc_tgl;
            @(negedge clk);
            got  = {state, osc_rdy, osc_lost};
            expv = exp_q.pop_front();
            n_checks++;
            if (got !== expv)
                $display("FAIL keepalive cyc %0d: got st/rdy/lost=%0d/%0b/%0b expected %0d/%0b/%0b",
                         k, got[3:2], got[1], got[0], expv[3:2], expv[1], expv[0]);
            else n_pass++;
        end
        clr_lost = 1'b0;
    endtask

    // A toggle changed after edge 4 reaches the FSM at edge 7, exactly when wd_cnt==3.
    task automatic test_tie();
        logic [3:0] got, expv;
        int k;
        do_reset();
        cfg_settle  = 8'd0;
        cfg_timeout = 8'd4;
        dly_q       = 1'b1;
        push_seq("IIRRRRRRRRL");
        k = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            k++;
            #1;
            if (k == 4) osc_tgl = ~osc_tgl;
            @(negedge clk);
            got  = {state, osc_rdy, osc_lost};
            expv = exp_q.pop_front();
            n_checks++;
            if (got !== expv)
                $display("FAIL tie cyc %0d: got st/rdy/lost=%0d/%0b/%0b expected %0d/%0b/%0b",
                         k, got[3:2], got[1], got[0], expv[3:2], expv[1], expv[0]);
            else n_pass++;
        end
    endtask

    // dly_q drops one cycle before SETTLE would finish, then returns and re-settles fully.
    task automatic test_drop_settle();
        logic [3:0] got, expv;
        int k;
        do_reset();
        cfg_settle  = 8'd5;
        cfg_timeout = 8'd0;
        dly_q       = 1'b1;
        push_seq("IISSSSIIIIIISSSSSR");
        k = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            k++;
            #1;
            if (k == 4)  dly_q = 1'b0;
            if (k == 10) dly_q = 1'b1;
            @(negedge clk);
            got  = {state, osc_rdy, osc_lost};
            expv = exp_q.pop_front();
            n_checks++;
            if (got !== expv)
                $display("FAIL drop_settle cyc %0d: got st/rdy/lost=%0d/%0b/%0b expected %0d/%0b/%0b",
                         k, got[3:2], got[1], got[0], expv[3:2], expv[1], expv[0]);
            else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] got, expv;
        int k;
        do_reset();
        cfg_settle  = 8'd0;
        cfg_timeout = 8'd0;
        dly_q       = 1'b1;
        push_seq("IIRR");
        k = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            got  = {state, osc_rdy, osc_lost};
            expv = exp_q.pop_front();
            n_checks++;
            if (got !== expv)
                $display("FAIL async_pre cyc %0d: got st/rdy/lost=%0d/%0b/%0b expected %0d/%0b/%0b",
                         k, got[3:2], got[1], got[0], expv[3:2], expv[1], expv[0]);
            else n_pass++;
        end
        @(posedge clk);
        #3 rstb = 1'b0;
        #1;
        n_checks++;
        if (osc_rdy !== 1'b0) $display("FAIL async_rdy: got %0b expected 0", osc_rdy);
        else n_pass++;
        n_checks++;
        if (state !== 2'd0) $display("FAIL async_state: got %0d expected 0", state);
        else n_pass++;
        @(posedge clk);
        #1 rstb = 1'b1;
        push_seq("IIR");
        k = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            k++;
            @(negedge clk);
            got  = {state, osc_rdy, osc_lost};
            expv = exp_q.pop_front();
            n_checks++;
            if (got !== expv)
                $display("FAIL async_post cyc %0d: got st/rdy/lost=%0d/%0b/%0b expected %0d/%0b/%0b",
                         k, got[3:2], got[1], got[0], expv[3:2], expv[1], expv[0]);
            else n_pass++;
        end
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_settle();
        test_zero_settle();
        test_watchdog();
        test_keepalive();
        test_tie();
        test_drop_settle();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
